// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between n_ports byte sources.
// Define UART_TX_ARBITER_LOCK_EN to hold the grant across multi-byte messages.
module uart_tx_arbiter #(
  parameter int n_ports      = 4,
  parameter int hold_timeout = 16
) (
  input  logic                 clock,
  input  logic                 i_rstn,
  input  logic [n_ports-1:0]   i_req,
  input  logic [8*n_ports-1:0] i_data,
  input  logic [n_ports-1:0]   i_last,
  input  logic                 i_cts,
  input  logic                 i_idle,
  output logic [7:0]           o_data,
  output logic                 o_req,
  output logic [n_ports-1:0]   o_ack,
  output logic [n_ports-1:0]   o_grant,
  output logic                 o_busy,
  output logic [31:0]          o_count
);

  localparam int IW = (n_ports > 1) ? $clog2(n_ports) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [n_ports-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [31:0]        count_q, count_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic               owner_req;
  logic               accept;
  logic [7:0]         port_byte [n_ports];

`ifdef UART_TX_ARBITER_LOCK_EN
  localparam int TW = $clog2(hold_timeout + 1);
  logic [TW-1:0] timeout_q, timeout_d;
  logic          owner_last;
  assign owner_last = |(i_last & grant_q);
`else
  logic unused_last;
  assign unused_last = ^i_last;
`endif

  // Each port's byte masked by its grant bit; OR-reduced into o_data.
  for (genvar gi = 0; gi < n_ports; gi++) begin : g_mask
    assign port_byte[gi] = i_data[8*gi +: 8] & {8{grant_q[gi]}};
  end

  always_comb begin
    o_data = 8'h00;
    for (int k = 0; k < n_ports; k++) begin
      o_data = o_data | port_byte[k];
    end
  end

  assign owner_req = |(i_req & grant_q);
  assign accept    = owner_req & i_cts;
  assign o_req     = owner_req;
  assign o_ack     = accept ? grant_q : '0;
  assign o_grant   = grant_q;
  assign o_busy    = (|grant_q) || !i_idle;
  assign o_count   = count_q;

  // Search starts just past the last winner, so it has lowest priority.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int off = 1; off <= n_ports; off++) begin
      idx = (int'(last_q) + off) % n_ports;
      if (!pick_found && i_req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
`ifdef UART_TX_ARBITER_LOCK_EN
    timeout_d = '0;
`endif
    if (accept) count_d = count_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = {{(n_ports-1){1'b0}}, 1'b1} << pick_idx;
          last_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
`ifdef UART_TX_ARBITER_LOCK_EN
        timeout_d = owner_req ? '0 : timeout_q + TW'(1);
        if ((accept && owner_last) ||
            (!owner_req && timeout_q == TW'(hold_timeout - 1))) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = '0;
        end
`else
        if (accept || !owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(n_ports - 1);
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

`ifdef UART_TX_ARBITER_LOCK_EN
  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) timeout_q <= '0;
    else         timeout_q <= timeout_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus stall, reset and lock sequences.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        i_rstn;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  i_last;
  logic        i_cts;
  logic        i_idle;
  logic [7:0]  o_data;
  logic        o_req;
  logic [3:0]  o_ack;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic [31:0] o_count;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.n_ports(4), .hold_timeout(16)) dut (
    .clock  (clock),
    .i_rstn (i_rstn),
    .i_req  (i_req),
    .i_data (i_data),
    .i_last (i_last),
    .i_cts  (i_cts),
    .i_idle (i_idle),
    .o_data (o_data),
    .o_req  (o_req),
    .o_ack  (o_ack),
    .o_grant(o_grant),
    .o_busy (o_busy),
    .o_count(o_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        do_rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        cts;
    logic        idle;
    logic [3:0]  exp_grant;
    logic        exp_req;
    logic [7:0]  exp_data;
    logic [3:0]  exp_ack;
    logic        exp_busy;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [31:0] data, logic cts,
                              logic idle, logic [3:0] g, logic oreq, logic [7:0] od,
                              logic [3:0] ack, logic busy, logic [31:0] cnt);
    vec_t v;
    v.do_rst = rst; v.req = req; v.data = data; v.cts = cts; v.idle = idle;
    v.exp_grant = g; v.exp_req = oreq; v.exp_data = od; v.exp_ack = ack;
    v.exp_busy = busy; v.exp_count = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Asserts reset, checks the held-in-reset outputs, releases at posedge+1.
  task automatic do_reset();
    i_rstn = 1'b0;
    i_idle = 1'b1;
    #1;
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_req",   32'(o_req),   32'h0);
    chk("rst_ack",   32'(o_ack),   32'h0);
    chk("rst_data",  32'(o_data),  32'h0);
    chk("rst_count", o_count,      32'h0);
    chk("rst_busy",  32'(o_busy),  32'h0);
    tick();
    i_rstn = 1'b1;
  endtask

  localparam logic [31:0] D1 = 32'h0000_0048;
  localparam logic [31:0] D2 = 32'hA3A2_A1A0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 1'b0; i_req = '0; i_data = '0; i_last = 4'hF; i_cts = 1'b0; i_idle = 1'b1;

    // Single byte from port 0, then round robin across all four ports.
    vecs.push_back(mk(1, 4'b0001, D1, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, D1, 1, 1, 4'h1, 1, 8'h48, 4'h1, 1, 0));
    vecs.push_back(mk(0, 4'b0000, D1, 1, 0, 4'h0, 0, 8'h00, 4'h0, 1, 1));
    vecs.push_back(mk(1, 4'b1111, D2, 0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, D2, 0, 1, 4'h1, 1, 8'hA0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h1, 1, 8'hA0, 4'h1, 1, 0));
    vecs.push_back(mk(0, 4'b1111, D2, 0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h2, 1, 8'hA1, 4'h2, 1, 1));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0, 2));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h4, 1, 8'hA2, 4'h4, 1, 2));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0, 3));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h8, 1, 8'hA3, 4'h8, 1, 3));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0, 4));
    vecs.push_back(mk(0, 4'b1111, D2, 1, 1, 4'h1, 1, 8'hA0, 4'h1, 1, 4));
    vecs.push_back(mk(0, 4'b0000, D2, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0, 5));
`ifndef UART_TX_ARBITER_LOCK_EN
    // Owner drops i_req while granted: released after one cycle without an ack.
    vecs.push_back(mk(0, 4'b0100, D2, 0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 5));
    vecs.push_back(mk(0, 4'b0000, D2, 1, 1, 4'h4, 0, 8'hA2, 4'h0, 1, 5));
    vecs.push_back(mk(0, 4'b0000, D2, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0, 5));
`endif

    tick();
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      i_req = vecs[i].req; i_data = vecs[i].data; i_cts = vecs[i].cts; i_idle = vecs[i].idle;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(o_grant), 32'(vecs[i].exp_grant));
      chk($sformatf("v%0d_req",   i), 32'(o_req),   32'(vecs[i].exp_req));
      chk($sformatf("v%0d_data",  i), 32'(o_data),  32'(vecs[i].exp_data));
      chk($sformatf("v%0d_ack",   i), 32'(o_ack),   32'(vecs[i].exp_ack));
      chk($sformatf("v%0d_busy",  i), 32'(o_busy),  32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_count", i), o_count,      vecs[i].exp_count);
      tick();
    end

    // Serializer stalls for 50 cycles while port 0 is granted.
    do_reset();
    i_req = 4'b0001; i_data = 32'h0000_005A; i_cts = 1'b0; i_idle = 1'b1;
    tick();
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("stall%0d_req", c),  32'(o_req),  32'h1);
      chk($sformatf("stall%0d_ack", c),  32'(o_ack),  32'h0);
      chk($sformatf("stall%0d_data", c), 32'(o_data), 32'h5A);
      tick();
    end
    i_cts = 1'b1;
    #1;
    chk("stall_release_ack", 32'(o_ack), 32'h1);
    tick();
    i_req = 4'b0000;
    #1;
    chk("stall_count", o_count, 32'h1);
    chk("stall_grant", 32'(o_grant), 32'h0);

    // Asynchronous reset in the middle of a grant.
    i_req = 4'b0100; i_cts = 1'b0;
    tick();
    chk("arst_pre_grant", 32'(o_grant), 32'h4);
    #3;
    i_rstn = 1'b0;
    #1;
    chk("arst_grant", 32'(o_grant), 32'h0);
    chk("arst_req",   32'(o_req),   32'h0);
    chk("arst_data",  32'(o_data),  32'h0);
    chk("arst_count", o_count,      32'h0);
    chk("arst_busy",  32'(o_busy),  32'h0);
    tick();
    i_rstn = 1'b1; i_req = 4'b1111;
    tick();
    chk("arst_first_win", 32'(o_grant), 32'h1);

`ifdef UART_TX_ARBITER_LOCK_EN
    // Port 2 sends a three-byte message while port 1 waits.
    do_reset();
    i_last = 4'b0000; i_req = 4'b0100; i_data = 32'h0010_2100; i_cts = 1'b1;
    #1;
    chk("lock_idle_grant", 32'(o_grant), 32'h0);
    tick();
    i_req = 4'b0110;
    for (int b = 0; b < 3; b++) begin
      i_data[23:16] = 8'(8'h10 + b);
      i_last = (b == 2) ? 4'b0100 : 4'b0000;
      #1;
      chk($sformatf("lock_b%0d_grant", b), 32'(o_grant), 32'h4);
      chk($sformatf("lock_b%0d_ack", b),   32'(o_ack),   32'h4);
      chk($sformatf("lock_b%0d_data", b),  32'(o_data),  32'(8'h10 + b));
      tick();
    end
    i_req = 4'b0010; i_last = 4'b0000;
    #1;
    chk("lock_after_grant", 32'(o_grant), 32'h0);
    tick();
    chk("lock_next_owner", 32'(o_grant), 32'h2);
    chk("lock_count", o_count, 32'h3);

    // Owner goes quiet mid-message; hold timeout releases the grant.
    do_reset();
    i_last = 4'b0000; i_req = 4'b0001; i_data = 32'h0000_0055; i_cts = 1'b1;
    tick();
    #1;
    chk("to_first_ack", 32'(o_ack), 32'h1);
    tick();
    i_req = 4'b1000;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("to_hold%0d", c), 32'(o_grant), 32'h1);
      tick();
    end
    chk("to_released", 32'(o_grant), 32'h0);
    tick();
    chk("to_port3", 32'(o_grant), 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
